pipe_ctrl_unit: RTL

//  Central hazard/sequencing controller for the Y86-64 five-stage pipeline. Drives the
//  F/D/E/M/W stall_i/bubble_i and set_cc controls from stage state: load-use,
//  ret, mispredicted-jump and exception rules. Adds registered run-state:

---
 rtl/y86_pkg.sv | 45 ++++
 rtl/pipe_ctrl_unit_hazard.sv | 46 ++++
 rtl/pipe_ctrl_unit.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings and the control bundle passed from the hazard core to the
// pipeline controller.
package y86_pkg;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [2:0] SAOK = 3'd1;
    localparam logic [2:0] SHLT = 3'd2;
    localparam logic [2:0] SADR = 3'd3;
    localparam logic [2:0] SINS = 3'd4;

    localparam logic [3:0] RNONE = 4'hF;

    typedef enum logic [1:0] {
        CPU_RUN    = 2'd0,
        CPU_FREEZE = 2'd1,
        CPU_STEP   = 2'd2,
        CPU_HALTED = 2'd3
    } cpu_state_e;

    typedef struct packed {
        logic f_stall;
        logic d_stall;
        logic e_stall;
        logic m_stall;
        logic w_stall;
        logic d_bubble;
        logic e_bubble;
        logic m_bubble;
        logic w_bubble;
        logic set_cc;
    } ctrl_t;

endpackage

// File: rtl/pipe_ctrl_unit_hazard.sv
// Pure combinational hazard core: load-use, ret, mispredict and exception rules
// turned into stage stall/bubble and CC-enable controls.
module hazard_detect
    import y86_pkg::*;
(
    input  logic [3:0] D_icode_i,
    input  logic [3:0] d_srcA_i,
    input  logic [3:0] d_srcB_i,
    input  logic [3:0] E_icode_i,
    input  logic [3:0] E_dstM_i,
    input  logic       e_cnd_i,
    input  logic [3:0] M_icode_i,
    input  logic [2:0] m_stat_i,
    input  logic [2:0] W_stat_i,
    output ctrl_t      ctrl_o,
    output logic       exc_w_o
);

    logic lu;
    logic ret;
    logic mis;
    logic exc_m;
    logic exc_w;

    always_comb begin
        lu    = ((E_icode_i == IMRMOVQ) || (E_icode_i == IPOPQ)) && (E_dstM_i != RNONE)
                && ((E_dstM_i == d_srcA_i) || (E_dstM_i == d_srcB_i));
        ret   = (D_icode_i == IRET) || (E_icode_i == IRET) || (M_icode_i == IRET);
        mis   = (E_icode_i == IJXX) && !e_cnd_i;
        exc_m = (m_stat_i != SAOK);
        exc_w = (W_stat_i != SAOK);

        ctrl_o          = '0;
        ctrl_o.f_stall  = lu | ret;
        ctrl_o.d_stall  = lu;
        // A mispredict squashes D even when a ret is also in flight.
        ctrl_o.d_bubble = mis | (!lu & ret);
        ctrl_o.e_bubble = mis | lu;
        ctrl_o.m_bubble = exc_m | exc_w;
        ctrl_o.w_stall  = exc_w;
        ctrl_o.set_cc   = (E_icode_i == IOPQ) && !exc_m && !exc_w;
    end

    assign exc_w_o = exc_w;

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipeline hazard/sequencing controller: hazard core plus run-state FSM
// (exception halt, debug freeze/step) and saturating cycle/stall counters.
module pipe_ctrl_unit
    import y86_pkg::*;
#(
    parameter int CNT_W  = 32,
    parameter bit DBG_EN = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [3:0]       D_icode_i,
    input  logic [3:0]       d_srcA_i,
    input  logic [3:0]       d_srcB_i,
    input  logic [3:0]       E_icode_i,
    input  logic [3:0]       E_dstM_i,
    input  logic             e_cnd_i,
    input  logic [3:0]       M_icode_i,
    input  logic [2:0]       m_stat_i,
    input  logic [2:0]       W_stat_i,
    input  logic             dbg_halt_req_i,
    input  logic             dbg_step_i,
    output logic             F_stall_o,
    output logic             D_stall_o,
    output logic             E_stall_o,
    output logic             M_stall_o,
    output logic             W_stall_o,
    output logic             F_bubble_o,
    output logic             D_bubble_o,
    output logic             E_bubble_o,
    output logic             M_bubble_o,
    output logic             W_bubble_o,
    output logic             set_cc_o,
    output logic [1:0]       cpu_state_o,
    output logic             dbg_halted_o,
    output logic [CNT_W-1:0] cycle_cnt_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    ctrl_t            core_ctrl;
    ctrl_t            ctrl;
    logic             exc_w;
    logic             dbg_req;
    logic             active;
    cpu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    hazard_detect u_hazard (
        .D_icode_i (D_icode_i),
        .d_srcA_i  (d_srcA_i),
        .d_srcB_i  (d_srcB_i),
        .E_icode_i (E_icode_i),
        .E_dstM_i  (E_dstM_i),
        .e_cnd_i   (e_cnd_i),
        .M_icode_i (M_icode_i),
        .m_stat_i  (m_stat_i),
        .W_stat_i  (W_stat_i),
        .ctrl_o    (core_ctrl),
        .exc_w_o   (exc_w)
    );

    assign dbg_req = DBG_EN && dbg_halt_req_i;
    assign active  = (state_q == CPU_RUN) || (state_q == CPU_STEP);

    // Reset forces a flush pattern immediately, independent of the clock.
    always_comb begin
        ctrl = '0;
        if (rst_i) begin
            ctrl.d_bubble = 1'b1;
            ctrl.e_bubble = 1'b1;
            ctrl.m_bubble = 1'b1;
            ctrl.w_bubble = 1'b1;
        end else if (active) begin
            ctrl = core_ctrl;
        end else begin
            ctrl.f_stall = 1'b1;
            ctrl.d_stall = 1'b1;
            ctrl.e_stall = 1'b1;
            ctrl.m_stall = 1'b1;
            ctrl.w_stall = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            CPU_RUN: begin
                if (exc_w)        state_d = CPU_HALTED;
                else if (dbg_req) state_d = CPU_FREEZE;
            end
            CPU_FREEZE: begin
                if (exc_w)           state_d = CPU_HALTED;
                else if (!dbg_req)   state_d = CPU_RUN;
                else if (dbg_step_i) state_d = CPU_STEP;
            end
            CPU_STEP: begin
                if (exc_w)        state_d = CPU_HALTED;
                else if (dbg_req) state_d = CPU_FREEZE;
                else              state_d = CPU_RUN;
            end
            default: state_d = CPU_HALTED;
        endcase
    end

    always_comb begin
        cycle_cnt_d = cycle_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (active && !(&cycle_cnt_q))
            cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
        if (active && ctrl.f_stall && !(&stall_cnt_q))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= CPU_RUN;
            cycle_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cycle_cnt_q <= cycle_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign F_stall_o    = ctrl.f_stall;
    assign D_stall_o    = ctrl.d_stall;
    assign E_stall_o    = ctrl.e_stall;
    assign M_stall_o    = ctrl.m_stall;
    assign W_stall_o    = ctrl.w_stall;
    assign F_bubble_o   = 1'b0;
    assign D_bubble_o   = ctrl.d_bubble;
    assign E_bubble_o   = ctrl.e_bubble;
    assign M_bubble_o   = ctrl.m_bubble;
    assign W_bubble_o   = ctrl.w_bubble;
    assign set_cc_o     = ctrl.set_cc;
    assign cpu_state_o  = state_q;
    assign dbg_halted_o = !rst_i && (state_q == CPU_FREEZE);
    assign cycle_cnt_o  = cycle_cnt_q;
    assign stall_cnt_o  = stall_cnt_q;

endmodule
